// File: rtl/ascii_to_bcd_parser.sv
// Assembles ASCII decimal digits from the UART receive stream into packed BCD.
// A CR/LF terminator publishes the number (bcd_valid) or rejects a malformed line (err).
module ascii_to_bcd_parser #(
  parameter int NDIGITS = 4,
  localparam int AW = 4 * NDIGITS,
  localparam int CW = $clog2(NDIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [AW-1:0] bcd,
  output logic [CW-1:0] bcd_ndigits,
  output logic          bcd_valid,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  logic          is_digit;
  logic          is_term;
  logic [3:0]    nibble;

  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    nibble   = rx_data[3:0];
  end

  // Terminators in IDLE are ignored so CR+LF pairs and blank lines stay silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      bcd         <= '0;
      bcd_ndigits <= '0;
      bcd_valid   <= 1'b0;
      err         <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      err       <= 1'b0;
      if (rx_valid) begin
        unique case (state)
          IDLE: begin
            if (is_digit) begin
              acc   <= AW'(nibble);
              cnt   <= CW'(1);
              state <= COLLECT;
            end else if (!is_term) begin
              state <= DISCARD;
            end
          end
          COLLECT: begin
            if (is_digit) begin
              if (cnt < CW'(NDIGITS)) begin
                acc <= (acc << 4) | AW'(nibble);
                cnt <= cnt + CW'(1);
              end else begin
                state <= DISCARD;
              end
            end else if (is_term) begin
              bcd         <= acc;
              bcd_ndigits <= cnt;
              bcd_valid   <= 1'b1;
              acc         <= '0;
              cnt         <= '0;
              state       <= IDLE;
            end else begin
              state <= DISCARD;
            end
          end
          DISCARD: begin
            // Everything up to the terminator belongs to the rejected line.
            if (is_term) begin
              err   <= 1'b1;
              acc   <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_to_bcd_parser.sv
// Scoreboard bench for ascii_to_bcd_parser: a line-level model predicts each
// strobe when the terminator is driven; the monitor pops and checks it.
module tb_ascii_to_bcd_parser;

  localparam int NDIGITS = 4;

  typedef struct {
    bit          isErr;
    logic [15:0] bcd;
    logic [2:0]  nd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] bcd;
  logic [2:0]  bcd_ndigits;
  logic        bcd_valid;
  logic        err;

  int          vectorCount = 0;
  int          missCount = 0;
  int          cycle = 0;
  exp_t        expQ[$];

  // Line model state
  bit          lineActive = 0;
  bit          lineBad = 0;
  int          lineLen = 0;
  logic [15:0] lineVal = '0;
  logic [15:0] lastBcd = '0;
  logic [2:0]  lastNd = '0;

  ascii_to_bcd_parser #(.NDIGITS(NDIGITS)) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .bcd(bcd),
    .bcd_ndigits(bcd_ndigits),
    .bcd_valid(bcd_valid),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic void modelClear();
    lineActive = 0;
    lineBad = 0;
    lineLen = 0;
    lineVal = '0;
  endfunction

  // Drives one byte; the DUT samples it on the next edge, strobe visible one cycle later.
  task automatic applyStimulus(input byte b);
    exp_t e;
    @(posedge clk);
    #1;
    rx_data = b;
    rx_valid = 1'b1;
    if (b == 8'h0D || b == 8'h0A) begin
      if (lineActive) begin
        e.cyc = cycle + 1;
        if (lineBad || lineLen > NDIGITS) begin
          e.isErr = 1;
          e.bcd = lastBcd;
          e.nd = lastNd;
        end else begin
          e.isErr = 0;
          e.bcd = lineVal;
          e.nd = 3'(lineLen);
          lastBcd = lineVal;
          lastNd = 3'(lineLen);
        end
        expQ.push_back(e);
      end
      modelClear();
    end else begin
      lineActive = 1;
      if (b >= 8'h30 && b <= 8'h39) begin
        lineLen++;
        if (lineLen <= NDIGITS) lineVal = {lineVal[11:0], b[3:0]};
      end else begin
        lineBad = 1;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic sendString(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i]);
      if (gaps) idleCycles(1);
    end
  endtask

  // Reset with a digit strobe pending in the same cycle; reset must win.
  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = "9";
    modelClear();
    lastBcd = '0;
    lastNd = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      checkOutput("strobeInReset", {30'd0, bcd_valid, err}, 32'd0);
    end else if (bcd_valid || err) begin
      if (bcd_valid && err) checkOutput("exclusiveStrobes", 32'd1, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("spuriousStrobe", {30'd0, bcd_valid, err}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("strobeKindErr", {31'd0, err}, {31'd0, e.isErr});
        checkOutput("strobeKindValid", {31'd0, bcd_valid}, {31'd0, !e.isErr});
        checkOutput("strobeCycle", cycle, e.cyc);
        checkOutput("bcd", {16'd0, bcd}, {16'd0, e.bcd});
        checkOutput("bcdNdigits", {29'd0, bcd_ndigits}, {29'd0, e.nd});
      end
    end else if (expQ.size() != 0 && cycle > expQ[0].cyc) begin
      checkOutput("missedStrobe", cycle, expQ[0].cyc);
      void'(expQ.pop_front());
    end
  end

  task automatic checkHeld(input string tag);
    @(negedge clk);
    checkOutput({tag, "Bcd"}, {16'd0, bcd}, {16'd0, lastBcd});
    checkOutput({tag, "Nd"}, {29'd0, bcd_ndigits}, {29'd0, lastNd});
  endtask

  initial begin
    int pick;
    byte alphabet[14];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetBcd", {16'd0, bcd}, 32'd0);
    checkOutput("resetNd", {29'd0, bcd_ndigits}, 32'd0);
    checkOutput("resetStrobes", {30'd0, bcd_valid, err}, 32'd0);

    $display("[TB] basic 123 CR");
    sendString("123\r", 1'b0);
    idleCycles(3);
    checkHeld("after123");

    $display("[TB] 9876 CR LF back-to-back");
    sendString("9876\r\n", 1'b0);
    idleCycles(3);

    $display("[TB] overflow 12345 LF");
    sendString("12345\n", 1'b0);
    idleCycles(3);
    checkHeld("afterOverflow");

    $display("[TB] bad char then 7");
    sendString("4A2\r", 1'b1);
    sendString("7\r", 1'b0);
    idleCycles(3);

    $display("[TB] lone terminators");
    sendString("\r", 1'b1);
    sendString("\n", 1'b1);
    sendString("\r\r", 1'b0);
    idleCycles(3);
    checkHeld("afterBlank");

    $display("[TB] 0042 and digit right after terminator");
    sendString("0042\r5\n", 1'b0);
    idleCycles(3);

    $display("[TB] reset mid-line");
    sendString("56", 1'b0);
    pulseReset();
    @(negedge clk);
    checkOutput("postResetBcd", {16'd0, bcd}, 32'd0);
    checkOutput("postResetNd", {29'd0, bcd_ndigits}, 32'd0);
    idleCycles(2);
    sendString("8\r", 1'b0);
    idleCycles(3);
    checkHeld("afterReset");

    $display("[TB] random byte stream");
    alphabet = '{"0", "1", "2", "3", "4", "5", "6", "7", "8", "9",
                 8'h0D, 8'h0A, "A", " "};
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 13);
      if (pick < 10 && $urandom_range(0, 3) == 0) pick = 10;
      applyStimulus(alphabet[pick]);
      if ($urandom_range(0, 4) == 0) idleCycles(1);
    end
    applyStimulus(8'h0D);
    idleCycles(4);
    checkHeld("afterRandom");

    checkOutput("pendingExpectations", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
